// File: rtl/trig_pkg.sv
// trig_pkg: state encoding, real-valued Taylor coefficient tables and
// the fixed-point scaling helper shared by the trig series engine.
package trig_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUARE,
        S_HORNER,
        S_FINAL,
        S_DONE
    } trig_state_e;

    localparam int MAX_TERMS = 8;

    // (-1)^k / (2k)!
    localparam real COS_COEF [0:7] = '{
        1.0,
        -1.0 / 2.0,
        1.0 / 24.0,
        -1.0 / 720.0,
        1.0 / 40320.0,
        -1.0 / 3628800.0,
        1.0 / 479001600.0,
        -1.0 / 87178291200.0
    };

    // (-1)^k / (2k+1)!
    localparam real SIN_COEF [0:7] = '{
        1.0,
        -1.0 / 6.0,
        1.0 / 120.0,
        -1.0 / 5040.0,
        1.0 / 362880.0,
        -1.0 / 39916800.0,
        1.0 / 6227020800.0,
        -1.0 / 1307674368000.0
    };

    // int'() of a real rounds half away from zero
    function automatic int scale_coef(input real c, input int frac);
        return int'(c * (2.0 ** frac));
    endfunction

endpackage

// File: rtl/trig_series_engine_if.sv
// trig_series_engine_if: start/ready request bus of the trig engine.
// master drives start/mode/x; slave returns ans/ans_ready/busy/range_err.
interface trig_series_engine_if #(
    parameter int X_W = 16
) ();

    logic                  start;
    logic                  mode;
    logic signed [X_W-1:0] x;
    logic signed [X_W-1:0] ans;
    logic                  ans_ready;
    logic                  busy;
    logic                  range_err;

    modport master (
        output start, mode, x,
        input  ans, ans_ready, busy, range_err
    );

    modport slave (
        input  start, mode, x,
        output ans, ans_ready, busy, range_err
    );

endinterface

// File: rtl/trig_coef_rom.sv
// trig_coef_rom: combinational Taylor coefficient lookup.
// Ports: mode_i (0 cos, 1 sin), k_i term index, c_o scaled coefficient.
module trig_coef_rom
    import trig_pkg::*;
#(
    parameter int X_W     = 16,
    parameter int FRAC    = 14,
    parameter int N_TERMS = 5
) (
    input  logic                  mode_i,
    input  logic [2:0]            k_i,
    output logic signed [X_W-1:0] c_o
);

    logic signed [X_W-1:0] cos_tab [MAX_TERMS];
    logic signed [X_W-1:0] sin_tab [MAX_TERMS];

    for (genvar i = 0; i < MAX_TERMS; i++) begin : g_tab
        localparam int CosI = scale_coef(COS_COEF[i], FRAC);
        localparam int SinI = scale_coef(SIN_COEF[i], FRAC);
        assign cos_tab[i] = (i < N_TERMS) ? X_W'(CosI) : '0;
        assign sin_tab[i] = (i < N_TERMS) ? X_W'(SinI) : '0;
    end

    always_comb begin
        c_o = mode_i ? sin_tab[k_i] : cos_tab[k_i];
    end

endmodule

// File: rtl/trig_series_engine.sv
// trig_series_engine: cos/sin by Horner evaluation of a Taylor series in x^2
// on one shared signed multiplier. Ports: clk, rst (async, active low),
// bus (slave): start/mode/x in; ans/ans_ready/busy/range_err out.
module trig_series_engine
    import trig_pkg::*;
#(
    parameter int X_W     = 16,
    parameter int FRAC    = 14,
    parameter int N_TERMS = 5,
    parameter int PI_HALF = 25736
) (
    input logic                 clk,
    input logic                 rst,
    trig_series_engine_if.slave bus
);

    // acc carries one guard bit; x^2 of the most negative x needs
    // 2*X_W-FRAC bits to stay unwrapped.
    localparam int AW   = X_W + 1;
    localparam int X2_W = 2 * X_W - FRAC;
    localparam int PW   = AW + X2_W;

    trig_state_e state_q, state_d;

    logic signed [X_W-1:0]  x_q, x_d;
    logic signed [X_W-1:0]  ans_q, ans_d;
    logic signed [X2_W-1:0] x2_q, x2_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [2:0]             k_q, k_d;
    logic                   mode_q, mode_d;
    logic                   rerr_q, rerr_d;

    logic signed [AW-1:0]   mul_a;
    logic signed [X2_W-1:0] mul_b;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   prod_sh;
    logic signed [X_W-1:0]  coef;
    logic signed [AW-1:0]   x_ext;
    logic signed [AW-1:0]   x_abs;

    function automatic logic signed [X_W-1:0] sat(
        input logic signed [AW-1:0] v
    );
        if (v[AW-1] != v[AW-2]) begin
            return v[AW-1] ? {1'b1, {(X_W-1){1'b0}}}
                           : {1'b0, {(X_W-1){1'b1}}};
        end
        return v[X_W-1:0];
    endfunction

    trig_coef_rom #(
        .X_W    (X_W),
        .FRAC   (FRAC),
        .N_TERMS(N_TERMS)
    ) u_rom (
        .mode_i(mode_q),
        .k_i   (k_q),
        .c_o   (coef)
    );

    assign prod    = PW'(mul_a) * PW'(mul_b);
    assign prod_sh = prod >>> FRAC;

    assign x_ext = AW'(bus.x);
    assign x_abs = x_ext[AW-1] ? -x_ext : x_ext;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        x2_d    = x2_q;
        acc_d   = acc_q;
        k_d     = k_q;
        mode_d  = mode_q;
        rerr_d  = rerr_q;
        ans_d   = ans_q;
        mul_a   = acc_q;
        mul_b   = x2_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x;
                    mode_d  = bus.mode;
                    rerr_d  = x_abs > AW'(PI_HALF);
                    k_d     = 3'(N_TERMS - 1);
                    state_d = S_SQUARE;
                end
            end
            S_SQUARE: begin
                mul_a   = AW'(x_q);
                mul_b   = X2_W'(x_q);
                x2_d    = X2_W'(prod_sh);
                acc_d   = AW'(coef);
                k_d     = 3'(N_TERMS - 2);
                state_d = S_HORNER;
            end
            S_HORNER: begin
                acc_d = AW'(prod_sh) + AW'(coef);
                if (k_q == 3'd0) begin
                    if (mode_q) begin
                        state_d = S_FINAL;
                    end else begin
                        ans_d   = sat(acc_d);
                        state_d = S_DONE;
                    end
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            S_FINAL: begin
                mul_b   = X2_W'(x_q);
                acc_d   = AW'(prod_sh);
                ans_d   = sat(acc_d);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            x2_q    <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            rerr_q  <= 1'b0;
            ans_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            x2_q    <= x2_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            rerr_q  <= rerr_d;
            ans_q   <= ans_d;
        end
    end

    // ans is loaded on the edge into DONE, so it is new while ans_ready is high
    assign bus.ans       = ans_q;
    assign bus.ans_ready = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.range_err = rerr_q;

endmodule

// File: tb/tb_trig_series_engine.sv
// tb_trig_series_engine: scoreboard bench for trig_series_engine with
// directed corner cases and random operands against a plain-arithmetic model.
module tb_trig_series_engine;

    localparam int X_W     = 16;
    localparam int FRAC    = 14;
    localparam int N_TERMS = 5;
    localparam int PI_HALF = 25736;

    typedef struct {
        longint ans;
        bit     rerr;
        int     exp_cyc;
        bit     has_ref;
        int     ref_val;
        int     tol;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t it;

    trig_series_engine_if #(.X_W(X_W)) bus ();

    trig_series_engine #(
        .X_W    (X_W),
        .FRAC   (FRAC),
        .N_TERMS(N_TERMS),
        .PI_HALF(PI_HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic check_tol(input string nm, input longint act,
                             input longint ref_v, input longint tol);
        longint d = act - ref_v;
        n_chk++;
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d +-%0d", nm, act, ref_v, tol);
    endtask

    // c_k = round((-1)^k / (2k+m)! * 2^FRAC)
    function automatic longint coef(input bit m, input int k);
        real f = 1.0;
        int  n = 2 * k + (m ? 1 : 0);
        for (int i = 2; i <= n; i++) f = f * i;
        return longint'(((k % 2) ? -1.0 : 1.0) * real'(1 << FRAC) / f);
    endfunction

    function automatic exp_t model(input bit m, input logic signed [X_W-1:0] xv);
        exp_t   e;
        longint xx = longint'(xv);
        longint x2;
        longint acc;
        x2  = (xx * xx) >>> FRAC;
        acc = coef(m, N_TERMS - 1);
        for (int k = N_TERMS - 2; k >= 0; k--)
            acc = ((acc * x2) >>> FRAC) + coef(m, k);
        if (m) acc = (acc * xx) >>> FRAC;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        e.ans     = acc;
        e.rerr    = ((xx < 0) ? -xx : xx) > PI_HALF;
        e.exp_cyc = 0;
        e.has_ref = 1'b0;
        e.ref_val = 0;
        e.tol     = 0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic issue(input bit m, input int xv, input bit hr,
                         input int rv, input int tl);
        exp_t e;
        int   n = 0;
        logic signed [X_W-1:0] xs = X_W'(xv);
        while (bus.busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("idle_wait", 0, 1);
        e = model(m, xs);
        e.exp_cyc = cyc + N_TERMS + 1 + (m ? 1 : 0);
        e.has_ref = hr;
        e.ref_val = rv;
        e.tol     = tl;
        sb.push_back(e);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.x     = xs;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode  = 1'($urandom);
        bus.x     = X_W'($urandom);
        check("rerr_capture", bus.range_err, e.rerr);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && bus.ans_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_ans_ready", 1, 0);
            end else begin
                it = sb.pop_front();
                check("ans", bus.ans, it.ans);
                check("range_err", bus.range_err, it.rerr);
                check("latency", cyc, it.exp_cyc);
                if (it.has_ref) check_tol("ans_ref", bus.ans, it.ref_val, it.tol);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.x     = '0;
        repeat (3) @(negedge clk);
        check("rst_ans", bus.ans, 0);
        check("rst_ready", bus.ans_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rerr", bus.range_err, 0);
        rst = 1'b1;
        @(negedge clk);

        issue(1'b0, 0, 1'b1, 16384, 0);
        for (int n = 1; n <= 7; n++) begin
            check("busy_window", bus.busy, (n <= 6) ? 1 : 0);
            @(negedge clk);
        end

        issue(1'b1, 25736, 1'b1, 16384, 4);
        issue(1'b0, 16384, 1'b1, 8852, 3);
        issue(1'b0, -16384, 1'b1, 8852, 3);
        issue(1'b1, -8192, 1'b1, -7855, 3);
        issue(1'b1, 32767, 1'b0, 0, 0);
        issue(1'b1, 0, 1'b1, 0, 0);
        issue(1'b0, -32768, 1'b0, 0, 0);
        issue(1'b0, 100, 1'b0, 0, 0);

        issue(1'b0, 16384, 1'b1, 8852, 3);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        bus.x     = -16'sd5000;
        @(negedge clk);
        bus.start = 1'b0;

        issue(1'b0, 12345, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete(sb.size() - 1);
        #1;
        check("midrst_ans", bus.ans, 0);
        check("midrst_ready", bus.ans_ready, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rerr", bus.range_err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(1'b1, 12345, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom), int'($urandom_range(0, 65535)) - 32768, 1'b0, 0, 0);
        end

        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        check("scoreboard_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
